jcmd_ep_out_buf: RTL
====================

# jcmd_ep_out_buf

Command-side USB OUT endpoint buffer: captures one host packet from the USB device core's receive byte stream into on-chip RAM and presents it to the Joker command processor via the hasdata/len/addr/q/arm/arm_ack interface. It is the producer end of the EP2 OUT command path: it holds exactly one packet until the consumer releases it, and NAKs new packets meanwhile. It sits between the USB device core and the command decoder.

## Interface
- ADDR_W, 10, RAM address width; depth 2^ADDR_W bytes.
- LEN_W, 10, width of buf_out_len; max accepted packet = 2^LEN_W-1 bytes.
- clk  in  1  system clock (50 MHz).
- reset  in  1  reset, synchronous, active-low; clock clk.
- rx_valid  in  1  byte strobe from USB core.
- rx_data  in  8  received byte, valid with rx_valid.
- rx_last  in  1  last byte of packet, qualified by rx_valid.
- rx_err  in  1  CRC/PID error for current packet (any cycle before/with rx_last).
- rx_nak  out  1  1 = buffer occupied, USB core must NAK OUT tokens.
- buf_out_hasdata  out  1  complete packet available.
- buf_out_len  out  LEN_W  byte count of held packet.
- buf_out_addr  in  11  consumer read address.
- buf_out_q  out  8  read data.
- buf_out_arm  in  1  level; consumer releases buffer.
- buf_out_arm_ack  out  1  one-cycle release acknowledge pulse.
- rx_overflow  out  1  sticky; packet longer than max dropped; cleared by reset.

## Operation
- States: S_RX (accepting), S_FULL (packet held), S_ACK (pulse ack), S_WAIT (wait arm low).
- S_RX: each rx_valid writes rx_data at wr_ptr, wr_ptr++. On rx_valid&rx_last: if no error and no overflow, latch len = wr_ptr+1, go S_FULL; else reset wr_ptr to 0, stay S_RX.
- rx_err at any point in a packet marks it bad; dropped at rx_last, wr_ptr to 0.
- Byte count reaching 2^LEN_W (before rx_last): set rx_overflow, stop writing, drop packet at rx_last.
- S_FULL: hasdata=1, rx_nak=1; rx_valid ignored (no RAM write). On buf_out_arm=1 → S_ACK.
- S_ACK: arm_ack=1 for exactly one cycle, hasdata=0, wr_ptr=0 → S_WAIT.
- S_WAIT: rx_nak=1 until buf_out_arm=0, then → S_RX. Prevents a stale arm level from releasing the next packet.
- Reads: buf_out_q = RAM[buf_out_addr[ADDR_W-1:0]]; addr bit 10 set → q=8'h00. Reads valid in all states; contents defined only in S_FULL.
- buf_out_len holds value from S_FULL entry until next S_FULL entry.

## Timing
- Reset (reset=0 at clk edge): state S_RX, wr_ptr=0, hasdata=0, len=0, q=0, arm_ack=0, rx_nak=0, rx_overflow=0. Reset mid-packet discards partial packet.
- rx_last byte at edge N → hasdata=1, rx_nak=1 from N+1.
- Read latency: addr sampled at edge N, q valid after edge N+1 (registered RAM output); consumer waiting ≥2 cycles is safe.
- arm seen high at edge N (S_FULL) → arm_ack=1 and hasdata=0 during cycle N+1, arm_ack=0 from N+2.
- rx_nak deasserts first cycle after arm observed low in S_WAIT.
- rx_valid during S_ACK/S_WAIT: ignored, no write (rx_nak already high).
- Back-to-back rx_valid every cycle supported in S_RX.

## Structure
- Shared package jcmd_pkg: state encoding, EP buffer widths (ADDR_W/LEN_W defaults), J_CMD_* opcodes shared with command decoder.
- One sub-module: jcmd_dpram — simple dual-port 2^ADDR_W×8 RAM, one write port, one registered read port, no reset on storage.

## Test plan
- Send 3-byte packet 0x10,0x44,0xA5 → hasdata=1, len=3; addr 0/1/2 → q=0x10/0x44/0xA5 after 1 cycle; addr 0x400 → q=0x00.
- With hasdata=1 send second packet → rx_nak=1, RAM/len unchanged; then arm=1 → single arm_ack pulse, hasdata=0; hold arm 5 cycles → no second ack, rx_nak=1 until arm=0.
- Packet with rx_err on byte 2 of 4 → no hasdata, next good 2-byte packet gives len=2.
- 1024-byte packet → rx_overflow=1, no hasdata; following 1023-byte packet → len=1023, last byte readable at addr 1022.
- Assert reset mid-packet after 5 bytes → all outputs at reset values; next 1-byte packet gives len=1.
- Single-byte packet (rx_valid&rx_last same cycle) → len=1, hasdata next cycle.

Source files
------------

// File: rtl/jcmd_pkg.sv
// Shared definitions for the Joker command path: EP2 OUT buffer state
// encoding, default buffer widths and the command opcodes that the command
// decoder also uses.
package jcmd_pkg;

    localparam int EP_ADDR_W = 10;
    localparam int EP_LEN_W  = 10;

    // state  | meaning
    // S_RX   | accepting bytes from the USB core
    // S_FULL | one complete packet held for the consumer
    // S_ACK  | one-cycle release acknowledge
    // S_WAIT | waiting for the consumer to drop arm
    typedef enum logic [1:0] {
        S_RX   = 2'd0,
        S_FULL = 2'd1,
        S_ACK  = 2'd2,
        S_WAIT = 2'd3
    } ep_state_e;

    localparam logic [7:0] J_CMD_NOP      = 8'h00;
    localparam logic [7:0] J_CMD_RESET    = 8'h01;
    localparam logic [7:0] J_CMD_REG_WR   = 8'h10;
    localparam logic [7:0] J_CMD_REG_RD   = 8'h11;
    localparam logic [7:0] J_CMD_STREAM   = 8'h20;

endpackage

// File: rtl/jcmd_dpram.sv
// Simple dual-port byte RAM: one write port, one registered read port.
// Storage is deliberately not reset.
module jcmd_dpram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem [2**ADDR_W];
    logic [7:0] rdata_q;

    // write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // registered read port
    always_ff @(posedge clk) begin
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/jcmd_ep_out_buf.sv
// EP2 OUT command buffer: captures one host packet into RAM, holds it for the
// command processor until released via arm/arm_ack, and NAKs meanwhile.
module jcmd_ep_out_buf
    import jcmd_pkg::*;
#(
    parameter int ADDR_W = EP_ADDR_W,
    parameter int LEN_W  = EP_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             rx_last,
    input  logic             rx_err,
    output logic             rx_nak,
    output logic             buf_out_hasdata,
    output logic [LEN_W-1:0] buf_out_len,
    input  logic [10:0]      buf_out_addr,
    output logic [7:0]       buf_out_q,
    input  logic             buf_out_arm,
    output logic             buf_out_arm_ack,
    output logic             rx_overflow
);

    // A byte arriving with wr_ptr at all-ones would be byte number 2^LEN_W,
    // which no longer fits in buf_out_len, so the pointer never passes it.
    localparam logic [LEN_W-1:0] PTR_MAX = {LEN_W{1'b1}};

    ep_state_e        state_q, state_d;
    logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             pkt_bad_q, pkt_bad_d;
    logic             rx_overflow_q, rx_overflow_d;
    logic             addr_hi_q;
    logic             ram_we;
    logic [7:0]       ram_rdata;

    // next state, datapath updates and Moore outputs
    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        len_d           = len_q;
        pkt_bad_d       = pkt_bad_q;
        rx_overflow_d   = rx_overflow_q;
        ram_we          = 1'b0;
        buf_out_hasdata = 1'b0;
        rx_nak          = 1'b0;
        buf_out_arm_ack = 1'b0;
        case (state_q)
            S_RX: begin
                if (rx_err) begin
                    pkt_bad_d = 1'b1;
                end
                if (rx_valid) begin
                    if (wr_ptr_q == PTR_MAX) begin
                        pkt_bad_d     = 1'b1;
                        rx_overflow_d = 1'b1;
                    end else begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + LEN_W'(1);
                    end
                    if (rx_last) begin
                        if (!pkt_bad_d) begin
                            len_d   = wr_ptr_q + LEN_W'(1);
                            state_d = S_FULL;
                        end
                        wr_ptr_d  = '0;
                        pkt_bad_d = 1'b0;
                    end
                end
            end
            S_FULL: begin
                buf_out_hasdata = 1'b1;
                rx_nak          = 1'b1;
                if (buf_out_arm) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                buf_out_arm_ack = 1'b1;
                rx_nak          = 1'b1;
                wr_ptr_d        = '0;
                state_d         = S_WAIT;
            end
            S_WAIT: begin
                rx_nak = 1'b1;
                if (!buf_out_arm) begin
                    state_d = S_RX;
                end
            end
            default: begin
                state_d = S_RX;
            end
        endcase
    end

    // state and datapath registers; addr_hi_q comes out of reset set so q
    // reads as zero without needing a reset on the RAM read register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_RX;
            wr_ptr_q      <= '0;
            len_q         <= '0;
            pkt_bad_q     <= 1'b0;
            rx_overflow_q <= 1'b0;
            addr_hi_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            len_q         <= len_d;
            pkt_bad_q     <= pkt_bad_d;
            rx_overflow_q <= rx_overflow_d;
            addr_hi_q     <= buf_out_addr[10];
        end
    end

    jcmd_dpram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (rx_data),
        .raddr_i (buf_out_addr[ADDR_W-1:0]),
        .rdata_o (ram_rdata)
    );

    assign buf_out_q   = addr_hi_q ? 8'h00 : ram_rdata;
    assign buf_out_len = len_q;
    assign rx_overflow = rx_overflow_q;

endmodule
